// File: rtl/cam_capture.sv
// -----------------------------------------------------------------------------
// cam_capture
//
// Receive side of the camera sensor interface. The raw sensor pins (PCLK,
// VSYNC, HREF, D[7:0]) are oversampled in the clk_125mhz domain. Rising edges
// of PCLK are detected, and byte pairs are packed into RGB565 pixels. Each
// pixel is tagged with its x/y position. The block also emits frame start,
// frame done and malformed-line markers.
//
// Optional feature: define CAM_FRAME_CNT_EN to add the frame_cnt output, a
// 16-bit wrapping count of completed frames.
//
// Parameters
//   H_ACTIVE    pixels per line (two bytes per pixel)
//   V_ACTIVE    lines per frame
//   SYNC_STAGES synchronizer depth on every camera input (>= 2)
//
// Ports
//   clk_125mhz   system clock
//   reset_n      asynchronous active-low reset (released synchronously upstream)
//   cam_pclk     raw sensor pixel clock
//   cam_vsync    raw frame sync, high = vertical blanking
//   cam_href     raw line valid, high = active bytes
//   cam_d        raw sensor data byte
//   capture_en   arm capture, only looked at on frame boundaries
//   pix_valid    one-cycle strobe, pixel outputs valid
//   pix_data     RGB565 pixel {first byte, second byte}
//   pix_x        pixel column, 0-based
//   pix_y        pixel row, 0-based
//   frame_start  one-cycle pulse when a captured frame begins
//   frame_done   one-cycle pulse when a captured frame ends
//   line_err     one-cycle pulse on a malformed line
//   frame_cnt    completed-frame counter (CAM_FRAME_CNT_EN only)
// -----------------------------------------------------------------------------
module cam_capture #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int SYNC_STAGES = 2
) (
   input  logic                         clk_125mhz,
   input  logic                         reset_n,
   input  logic                         cam_pclk,
   input  logic                         cam_vsync,
   input  logic                         cam_href,
   input  logic [7:0]                   cam_d,
   input  logic                         capture_en,
   output logic                         pix_valid,
   output logic [15:0]                  pix_data,
   output logic [$clog2(H_ACTIVE)-1:0]  pix_x,
   output logic [$clog2(V_ACTIVE)-1:0]  pix_y,
   output logic                         frame_start,
   output logic                         frame_done,
   output logic                         line_err
`ifdef CAM_FRAME_CNT_EN
   ,
   output logic [15:0]                  frame_cnt
`endif
);

   localparam int XW  = $clog2(H_ACTIVE);
   localparam int YW  = $clog2(V_ACTIVE);
   // Column/row counters must be able to hold H_ACTIVE / V_ACTIVE themselves
   // because they saturate there.
   localparam int XCW = $clog2(H_ACTIVE + 1);
   localparam int YCW = $clog2(V_ACTIVE + 1);
   localparam logic [XCW-1:0] X_MAX = XCW'(H_ACTIVE);
   localparam logic [YCW-1:0] Y_MAX = YCW'(V_ACTIVE);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_VS,
      ACTIVE,
      DONE
   } state_t;

   state_t state, state_next;

   logic [SYNC_STAGES-1:0] pclk_sync;
   logic [SYNC_STAGES-1:0] vsync_sync;
   logic [SYNC_STAGES-1:0] href_sync;
   logic [7:0]             d_sync [SYNC_STAGES];
   logic                   pclk_prev;

   logic                   edge_p0;
   logic                   vs_p0;
   logic                   href_p0;
   logic [7:0]             d_p0;
   logic                   vs_p1;
   logic                   href_p1;

   logic                   vs_rise;
   logic                   vs_fall;
   logic                   href_fall;
   logic                   start_frame;
   logic                   end_frame;

   logic [XCW-1:0]         x;
   logic [YCW-1:0]         y;
   logic                   phase;
   logic [7:0]             hi_byte;

   // ---- synchronizer stages ----
   always_ff @(posedge clk_125mhz or negedge reset_n) begin
      if (!reset_n) begin
         pclk_sync  <= '0;
         vsync_sync <= '0;
         href_sync  <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            d_sync[i] <= '0;
         end
      end else begin
         pclk_sync  <= {pclk_sync[SYNC_STAGES-2:0], cam_pclk};
         vsync_sync <= {vsync_sync[SYNC_STAGES-2:0], cam_vsync};
         href_sync  <= {href_sync[SYNC_STAGES-2:0], cam_href};
         d_sync[0]  <= cam_d;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            d_sync[i] <= d_sync[i-1];
         end
      end
   end

   // ---- p0: PCLK edge detect, sampled pins aligned with the edge flag ----
   always_ff @(posedge clk_125mhz or negedge reset_n) begin
      if (!reset_n) begin
         pclk_prev <= 1'b0;
         edge_p0   <= 1'b0;
         vs_p0     <= 1'b0;
         href_p0   <= 1'b0;
         d_p0      <= '0;
      end else begin
         pclk_prev <= pclk_sync[SYNC_STAGES-1];
         edge_p0   <= pclk_sync[SYNC_STAGES-1] & ~pclk_prev;
         vs_p0     <= vsync_sync[SYNC_STAGES-1];
         href_p0   <= href_sync[SYNC_STAGES-1];
         d_p0      <= d_sync[SYNC_STAGES-1];
      end
   end

   // ---- p1: previous vsync/href for level-change detection ----
   always_ff @(posedge clk_125mhz or negedge reset_n) begin
      if (!reset_n) begin
         vs_p1   <= 1'b0;
         href_p1 <= 1'b0;
      end else begin
         vs_p1   <= vs_p0;
         href_p1 <= href_p0;
      end
   end

   assign vs_rise   =  vs_p0 & ~vs_p1;
   assign vs_fall   = ~vs_p0 &  vs_p1;
   assign href_fall = ~href_p0 & href_p1;

   always_ff @(posedge clk_125mhz or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      start_frame = 1'b0;
      end_frame   = 1'b0;
      case (state)
         IDLE: begin
            // Arming needs vsync high, so a frame already in progress is
            // never joined part-way through.
            if (capture_en && vs_p0) begin
               state_next = WAIT_VS;
            end
         end
         WAIT_VS: begin
            if (vs_fall) begin
               state_next  = ACTIVE;
               start_frame = 1'b1;
            end
         end
         ACTIVE: begin
            if (vs_rise) begin
               state_next = DONE;
               end_frame  = 1'b1;
            end
         end
         DONE: begin
            state_next = capture_en ? WAIT_VS : IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---- p2: byte packing, position tracking and output registers ----
   always_ff @(posedge clk_125mhz or negedge reset_n) begin
      if (!reset_n) begin
         pix_valid   <= 1'b0;
         pix_data    <= '0;
         pix_x       <= '0;
         pix_y       <= '0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         line_err    <= 1'b0;
         x           <= '0;
         y           <= '0;
         phase       <= 1'b0;
         hi_byte     <= '0;
      end else begin
         pix_valid   <= 1'b0;
         line_err    <= 1'b0;
         frame_start <= start_frame;
         frame_done  <= end_frame;

         if (start_frame) begin
            x     <= '0;
            y     <= '0;
            phase <= 1'b0;
         end else if (state == ACTIVE) begin
            if (edge_p0 && href_p0) begin
               if (!phase) begin
                  hi_byte <= d_p0;
                  phase   <= 1'b1;
               end else begin
                  phase <= 1'b0;
                  // Columns past the line width are dropped and x parks at
                  // H_ACTIVE; rows past the frame height are never reported.
                  if (x < X_MAX) begin
                     x <= x + 1'b1;
                     if (y < Y_MAX) begin
                        pix_valid <= 1'b1;
                        pix_data  <= {hi_byte, d_p0};
                        pix_x     <= x[XW-1:0];
                        pix_y     <= y[YW-1:0];
                     end
                  end
               end
            end else if (href_fall && !vs_rise) begin
               // A line cut short by the frame ending is not a line error.
               line_err <= (x != X_MAX) || phase;
               x        <= '0;
               phase    <= 1'b0;
               if (y < Y_MAX) begin
                  y <= y + 1'b1;
               end
            end
         end
      end
   end

`ifdef CAM_FRAME_CNT_EN
   always_ff @(posedge clk_125mhz or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt <= '0;
      end else if (end_frame) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cam_capture.sv
// -----------------------------------------------------------------------------
// tb_cam_capture
//
// Bench for cam_capture with H_ACTIVE=4, V_ACTIVE=2, SYNC_STAGES=2. A sensor
// model drives PCLK/HREF/VSYNC/D; a reference model derives the expected pixel
// stream and line error count from the bytes sent per line.
// -----------------------------------------------------------------------------
module tb_cam_capture;

   localparam int H = 4;
   localparam int V = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cam_pclk;
   logic        cam_vsync;
   logic        cam_href;
   logic [7:0]  cam_d;
   logic        capture_en;
   logic        pix_valid;
   logic [15:0] pix_data;
   logic [1:0]  pix_x;
   logic [0:0]  pix_y;
   logic        frame_start;
   logic        frame_done;
   logic        line_err;
`ifdef CAM_FRAME_CNT_EN
   logic [15:0] frame_cnt;
   int          exp_frames;
`endif

   always #4 clk = ~clk;

   cam_capture #(
      .H_ACTIVE    (H),
      .V_ACTIVE    (V),
      .SYNC_STAGES (2)
   ) dut (
      .clk_125mhz  (clk),
      .reset_n     (reset_n),
      .cam_pclk    (cam_pclk),
      .cam_vsync   (cam_vsync),
      .cam_href    (cam_href),
      .cam_d       (cam_d),
      .capture_en  (capture_en),
      .pix_valid   (pix_valid),
      .pix_data    (pix_data),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .line_err    (line_err)
`ifdef CAM_FRAME_CNT_EN
      ,
      .frame_cnt   (frame_cnt)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Observed activity, packed pixels are {data, 8'x, 8'y}
   logic [31:0] got_pix [$];
   int          got_start, got_done, got_lerr, got_both;

   // Reference model results
   logic [31:0] exp_pix [$];
   int          exp_lerr;
   logic [7:0]  pat;

   always @(negedge clk) begin
      if (reset_n) begin
         if (pix_valid) got_pix.push_back({pix_data, 8'(pix_x), 8'(pix_y)});
         if (frame_start) got_start++;
         if (frame_done) got_done++;
         if (line_err) got_lerr++;
         if (pix_valid && frame_done) got_both++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_sb();
      got_pix.delete();
      exp_pix.delete();
      got_start = 0;
      got_done  = 0;
      got_lerr  = 0;
      got_both  = 0;
      exp_lerr  = 0;
   endtask

   task automatic note_frame();
`ifdef CAM_FRAME_CNT_EN
      exp_frames++;
`endif
   endtask

   task automatic send_byte(input logic [7:0] b, input int half);
      cam_d    = b;
      cam_pclk = 1'b0;
      tick(half);
      cam_pclk = 1'b1;
      tick(half);
   endtask

   // One HREF-framed line; the model turns the byte list into the pixels and
   // line errors a correct receiver must report.
   task automatic send_line(input int nbytes, input int half, input bit rnd,
                            input int row, input bit captured);
      logic [7:0] bytes [$];
      logic [7:0] b;
      int         npix;
      cam_href = 1'b1;
      tick(half);
      for (int i = 0; i < nbytes; i++) begin
         b   = rnd ? 8'($urandom) : pat;
         pat = pat + 8'h22;
         bytes.push_back(b);
         send_byte(b, half);
      end
      tick(half);
      cam_href = 1'b0;
      cam_pclk = 1'b0;
      tick(4 * half);
      if (captured) begin
         npix = (nbytes / 2 < H) ? nbytes / 2 : H;
         if (row < V) begin
            for (int i = 0; i < npix; i++)
               exp_pix.push_back({bytes[2*i], bytes[2*i+1], 8'(i), 8'(row)});
         end
         if ((nbytes % 2) != 0 || (nbytes / 2) < H) exp_lerr++;
      end
   endtask

   // capture_en is dropped before VSYNC rises, so each frame ends in IDLE.
   task automatic run_frame(input bit cap, input int nl, input int lens [3],
                            input int half, input bit rnd);
      pat        = 8'h12;
      cam_vsync  = 1'b1;
      capture_en = cap;
      tick(8);
      cam_vsync = 1'b0;
      tick(6);
      for (int l = 0; l < nl; l++) send_line(lens[l], half, rnd, l, cap);
      capture_en = 1'b0;
      tick(2);
      cam_vsync = 1'b1;
      tick(12);
      if (cap) note_frame();
   endtask

   task automatic compare_pixels(input string tag);
      int n;
      check({tag, "_pix_count"}, 32'(got_pix.size()), 32'(exp_pix.size()));
      n = (got_pix.size() < exp_pix.size()) ? got_pix.size() : exp_pix.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_pix%0d", tag, i), got_pix[i], exp_pix[i]);
   endtask

   typedef struct {
      bit cap;
      int nl;
      int len0, len1, len2;
      int half;
      int e_start, e_pix, e_lerr, e_done;
   } vec_t;

   vec_t vecs [4];
   int   lens [3];
   int   lat;
   bit   cap;

   initial begin
      vecs[0] = '{1, 2, 8, 8, 0, 4, 1, 8, 0, 1};   // basic frame
      vecs[1] = '{1, 3, 6, 7, 8, 2, 1, 6, 2, 1};   // short, odd, row clipped
      vecs[2] = '{1, 2, 10, 8, 0, 3, 1, 8, 0, 1};  // column clipped
      vecs[3] = '{0, 2, 8, 8, 0, 4, 0, 0, 0, 0};   // not armed

      reset_n    = 1'b0;
      cam_pclk   = 1'b0;
      cam_vsync  = 1'b1;
      cam_href   = 1'b0;
      cam_d      = 8'h00;
      capture_en = 1'b0;
`ifdef CAM_FRAME_CNT_EN
      exp_frames = 0;
`endif
      clear_sb();
      tick(5);
      check("reset_outputs",
            {7'd0, pix_valid, pix_data, pix_x, pix_y, frame_start, frame_done, line_err}, 32'd0);
      reset_n = 1'b1;
      tick(5);

      // Table-driven frames
      for (int v = 0; v < 4; v++) begin
         clear_sb();
         lens[0] = vecs[v].len0;
         lens[1] = vecs[v].len1;
         lens[2] = vecs[v].len2;
         run_frame(vecs[v].cap, vecs[v].nl, lens, vecs[v].half, 1'b0);
         check($sformatf("v%0d_start", v), 32'(got_start), 32'(vecs[v].e_start));
         check($sformatf("v%0d_done", v), 32'(got_done), 32'(vecs[v].e_done));
         check($sformatf("v%0d_lerr", v), 32'(got_lerr), 32'(vecs[v].e_lerr));
         check($sformatf("v%0d_npix", v), 32'(got_pix.size()), 32'(vecs[v].e_pix));
         compare_pixels($sformatf("v%0d", v));
         if (v == 0) begin
            check("v0_first_pixel", (got_pix.size() > 0) ? got_pix[0] : 32'hDEAD_BEEF,
                  {16'h1234, 8'd0, 8'd0});
            check("v0_data_hold", {16'd0, pix_data}, {16'd0, 16'hEE10});
         end
      end

      // Latency: pix_valid four clocks after the raw second-byte PCLK edge
      clear_sb();
      cam_vsync  = 1'b1;
      capture_en = 1'b1;
      tick(8);
      cam_vsync = 1'b0;
      tick(6);
      cam_href = 1'b1;
      tick(4);
      send_byte(8'hC3, 4);
      cam_d    = 8'h3C;
      cam_pclk = 1'b0;
      tick(4);
      cam_pclk = 1'b1;
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (pix_valid && lat == 0) lat = k;
      end
      check("latency", 32'(lat), 32'd4);
      check("latency_data", {16'd0, pix_data}, {16'd0, 16'hC33C});
      #1;
      cam_href = 1'b0;
      cam_pclk = 1'b0;
      capture_en = 1'b0;
      tick(8);
      cam_vsync = 1'b1;
      tick(12);
      note_frame();

      // Second byte and VSYNC rise together: pixel and frame_done coincide
      clear_sb();
      cam_vsync  = 1'b1;
      capture_en = 1'b1;
      tick(8);
      cam_vsync = 1'b0;
      tick(6);
      cam_href = 1'b1;
      tick(4);
      send_byte(8'hA5, 4);
      cam_d    = 8'h5A;
      cam_pclk = 1'b0;
      tick(4);
      cam_pclk   = 1'b1;
      cam_vsync  = 1'b1;
      capture_en = 1'b0;
      tick(4);
      cam_href = 1'b0;
      cam_pclk = 1'b0;
      tick(12);
      note_frame();
      exp_pix.push_back({16'hA55A, 8'd0, 8'd0});
      check("coincide_both", 32'(got_both), 32'd1);
      check("coincide_lerr", 32'(got_lerr), 32'd0);
      compare_pixels("coincide");

      // Reset in the middle of a line
      clear_sb();
      cam_vsync  = 1'b1;
      capture_en = 1'b1;
      tick(8);
      cam_vsync = 1'b0;
      tick(6);
      cam_href = 1'b1;
      tick(4);
      send_byte(8'h11, 4);
      send_byte(8'h22, 4);
      send_byte(8'h33, 4);
      send_byte(8'h44, 4);
      tick(2);
      check("pre_reset_data", {16'd0, pix_data}, {16'd0, 16'h3344});
      #1;
      reset_n = 1'b0;
      #1;
      check("async_reset_outputs",
            {7'd0, pix_valid, pix_data, pix_x, pix_y, frame_start, frame_done, line_err}, 32'd0);
`ifdef CAM_FRAME_CNT_EN
      exp_frames = 0;
`endif
      tick(2);
      reset_n = 1'b1;
      clear_sb();
      send_byte(8'h55, 4);
      send_byte(8'h66, 4);
      send_byte(8'h77, 4);
      send_byte(8'h88, 4);
      cam_href = 1'b0;
      cam_pclk = 1'b0;
      tick(10);
      check("post_reset_npix", 32'(got_pix.size()), 32'd0);
      check("post_reset_lerr", 32'(got_lerr), 32'd0);
      lens = '{8, 8, 0};
      run_frame(1'b1, 2, lens, 4, 1'b0);
      check("post_reset_start", 32'(got_start), 32'd1);
      compare_pixels("post_reset");

      // Randomized frames against the reference model
      for (int f = 0; f < 8; f++) begin
         clear_sb();
         cap = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 3; i++) lens[i] = $urandom_range(1, 11);
         run_frame(cap, $urandom_range(1, 3), lens, $urandom_range(2, 5), 1'b1);
         check($sformatf("rnd%0d_start", f), 32'(got_start), 32'(cap));
         check($sformatf("rnd%0d_done", f), 32'(got_done), 32'(cap));
         check($sformatf("rnd%0d_lerr", f), 32'(got_lerr), 32'(exp_lerr));
         compare_pixels($sformatf("rnd%0d", f));
      end

`ifdef CAM_FRAME_CNT_EN
      check("frame_cnt", {16'd0, frame_cnt}, 32'(exp_frames));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
